lsu_ctrl: RTL and testbench

- Load/store control stage that sits directly upstream of the byte-addressed data memory. It sits between execute and writeback.
- Accepts one decoded load/store per handshake and checks legality and alignment.
- Drives the memory port for exactly one access cycle, then captures the registered read data.
- Returns a writeback result (loads) or completion (stores), and raises a one-cycle exception for illegal or misaligned requests.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_ctrl_if.sv | 48 ++++
 rtl/lsu_req_check.sv | 43 ++++
 rtl/lsu_ctrl.sv | 148 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store control stage.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        RESP    = 3'd3,
        FAULT   = 3'd4
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_LMISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_SMISALIGN = 6'd6;

    // Unshifted byte-lane mask for an access size encoded in funct3[1:0].
    function automatic logic [3:0] byte_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request, memory-port, writeback and exception signals of the load/store stage.
// master = pipeline/memory side, slave = lsu_ctrl side.
interface lsu_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_load;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_base;
    logic [11:0]     req_offset;
    logic [XLEN-1:0] req_wdata;
    logic [4:0]      req_rd;

    logic [XLEN-1:0] mem_addr;
    logic [11:0]     mem_offset;
    logic [XLEN-1:0] mem_value;
    logic [2:0]      mem_funct3;
    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] mem_data;

    logic            wb_valid;
    logic            wb_ready;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            exc_valid;
    logic [3:0]      exc_cause;
    logic [XLEN-1:0] exc_addr;

    modport master (
        output req_valid, req_load, req_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
        output mem_data, wb_ready,
        input  req_ready, mem_addr, mem_offset, mem_value, mem_funct3, mem_read, mem_write,
        input  wb_valid, wb_we, wb_rd, wb_data, exc_valid, exc_cause, exc_addr
    );

    modport slave (
        input  req_valid, req_load, req_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
        input  mem_data, wb_ready,
        output req_ready, mem_addr, mem_offset, mem_value, mem_funct3, mem_read, mem_write,
        output wb_valid, wb_we, wb_rd, wb_data, exc_valid, exc_cause, exc_addr
    );

endinterface

// File: rtl/lsu_req_check.sv
// Combinational legality/alignment check of an incoming load/store request.
module lsu_req_check
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int CHECK_ALIGN = 1
) (
    input  logic            load,
    input  logic            store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] base,
    input  logic [11:0]     offset,
    output logic [XLEN-1:0] ea,
    output logic            illegal,
    output logic            misaligned,
    output logic [3:0]      cause
);

    always_comb begin
        ea = base + {{(XLEN-12){offset[11]}}, offset};

        illegal = 1'b0;
        if (load == store) begin
            illegal = 1'b1;
        end else if (load) begin
            illegal = !(funct3 inside {LB, LH, LW, LBU, LHU});
        end else begin
            illegal = !(funct3 inside {SB, SH, SW});
        end

        misaligned = 1'b0;
        if (CHECK_ALIGN != 0) begin
            if (funct3[1:0] == LH[1:0] && ea[0]) misaligned = 1'b1;
            if (funct3[1:0] == LW[1:0] && ea[1:0] != 2'b00) misaligned = 1'b1;
        end

        // Illegal wins over misaligned; the cause is only meaningful when one of them is set.
        if (illegal)   cause = CAUSE_ILLEGAL;
        else if (load) cause = CAUSE_LMISALIGN;
        else           cause = CAUSE_SMISALIGN;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage: registers one request, strobes memory for one cycle, returns writeback or exception.
// Define LSU_RVFI_EN to add the rvfi_mem_* trace outputs.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int CHECK_ALIGN = 1
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus,
    output logic       busy,
    output lsu_state_e state_dbg
`ifdef LSU_RVFI_EN
    ,
    output logic [XLEN-1:0] rvfi_mem_addr,
    output logic [3:0]      rvfi_mem_rmask,
    output logic [3:0]      rvfi_mem_wmask,
    output logic [XLEN-1:0] rvfi_mem_rdata,
    output logic [XLEN-1:0] rvfi_mem_wdata
`endif
);

    // Handshakes: a request transfers on the edge where req_valid && req_ready; a result
    // stays on wb_* unchanged until the edge where wb_valid && wb_ready.
    lsu_state_e state, state_next;

    logic            accept;
    logic [XLEN-1:0] chk_ea;
    logic            chk_illegal, chk_misaligned;
    logic [3:0]      chk_cause;

    logic            r_load, r_store;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_base, r_wdata, r_ea, r_rdata;
    logic [11:0]     r_offset;
    logic [4:0]      r_rd;
    logic [3:0]      r_cause;

    lsu_req_check #(.XLEN(XLEN), .CHECK_ALIGN(CHECK_ALIGN)) u_check (
        .load       (bus.req_load),
        .store      (bus.req_store),
        .funct3     (bus.req_funct3),
        .base       (bus.req_base),
        .offset     (bus.req_offset),
        .ea         (chk_ea),
        .illegal    (chk_illegal),
        .misaligned (chk_misaligned),
        .cause      (chk_cause)
    );

    assign accept = bus.req_valid && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = (chk_illegal || chk_misaligned) ? FAULT : ISSUE;
            ISSUE:   state_next = r_load ? CAPTURE : RESP;
            CAPTURE: state_next = RESP;
            RESP:    if (bus.wb_ready) state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset removes them at once.
    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.mem_read  = (state == ISSUE) && r_load;
        bus.mem_write = (state == ISSUE) && r_store;
        bus.wb_valid  = (state == RESP);
        bus.wb_we     = (state == RESP) && r_load;
        bus.exc_valid = (state == FAULT);
        busy          = (state != IDLE);
        state_dbg     = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load   <= 1'b0;
            r_store  <= 1'b0;
            r_funct3 <= '0;
            r_base   <= '0;
            r_offset <= '0;
            r_wdata  <= '0;
            r_rd     <= '0;
            r_ea     <= '0;
            r_cause  <= '0;
            r_rdata  <= '0;
        end else begin
            if (accept) begin
                r_load   <= bus.req_load;
                r_store  <= bus.req_store;
                r_funct3 <= bus.req_funct3;
                r_base   <= bus.req_base;
                r_offset <= bus.req_offset;
                r_wdata  <= bus.req_wdata;
                r_rd     <= bus.req_rd;
                r_ea     <= chk_ea;
                r_cause  <= chk_cause;
            end
            if (state == CAPTURE) r_rdata <= bus.mem_data;
        end
    end

    assign bus.mem_addr   = r_base;
    assign bus.mem_offset = r_offset;
    assign bus.mem_value  = r_wdata;
    assign bus.mem_funct3 = r_funct3;
    assign bus.wb_rd      = r_rd;
    assign bus.wb_data    = r_rdata;
    assign bus.exc_cause  = r_cause;
    assign bus.exc_addr   = r_ea;

`ifdef LSU_RVFI_EN
    // Trace fields are loaded at accept; a faulting request leaves them all zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvfi_mem_addr  <= '0;
            rvfi_mem_rmask <= '0;
            rvfi_mem_wmask <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
        end else if (accept) begin
            if (chk_illegal || chk_misaligned) begin
                rvfi_mem_addr  <= '0;
                rvfi_mem_rmask <= '0;
                rvfi_mem_wmask <= '0;
                rvfi_mem_wdata <= '0;
            end else begin
                rvfi_mem_addr  <= chk_ea;
                rvfi_mem_rmask <= bus.req_load  ? 4'(byte_mask(bus.req_funct3) << chk_ea[1:0]) : 4'd0;
                rvfi_mem_wmask <= bus.req_store ? 4'(byte_mask(bus.req_funct3) << chk_ea[1:0]) : 4'd0;
                rvfi_mem_wdata <= bus.req_store ? bus.req_wdata : '0;
            end
            rvfi_mem_rdata <= '0;
        end else if (state == CAPTURE) begin
            rvfi_mem_rdata <= bus.mem_data;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl against a request-level reference model and byte memory.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int XLEN = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_ctrl_if #(.XLEN(XLEN)) bus ();
    lsu_ctrl_if #(.XLEN(XLEN)) bus_na ();
    logic       busy, busy_na;
    lsu_state_e state_dbg, state_dbg_na;

    lsu_ctrl #(.XLEN(XLEN), .CHECK_ALIGN(1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .state_dbg(state_dbg)
    );

    // Second copy with alignment checking off, fed the same requests.
    lsu_ctrl #(.XLEN(XLEN), .CHECK_ALIGN(0)) u_dut_na (
        .clk(clk), .rst(rst), .bus(bus_na), .busy(busy_na), .state_dbg(state_dbg_na)
    );

    assign bus_na.req_valid  = bus.req_valid;
    assign bus_na.req_load   = bus.req_load;
    assign bus_na.req_store  = bus.req_store;
    assign bus_na.req_funct3 = bus.req_funct3;
    assign bus_na.req_base   = bus.req_base;
    assign bus_na.req_offset = bus.req_offset;
    assign bus_na.req_wdata  = bus.req_wdata;
    assign bus_na.req_rd     = bus.req_rd;
    assign bus_na.wb_ready   = 1'b1;
    assign bus_na.mem_data   = '0;

    int na_reads = 0;
    int na_exc   = 0;
    always @(negedge clk) begin
        if (bus_na.mem_read)  na_reads++;
        if (bus_na.exc_valid) na_exc++;
    end

    // ---------------- memory model ----------------
    bit [7:0]    mem     [0:1023];
    bit [7:0]    ref_mem [0:1023];
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] m_a;

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        case (f3)
            3'd0:    return {{24{raw[7]}}, raw[7:0]};
            3'd1:    return {{16{raw[15]}}, raw[15:0]};
            3'd4:    return {24'd0, raw[7:0]};
            3'd5:    return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    always @(posedge clk) begin
        m_a = bus.mem_addr + {{20{bus.mem_offset[11]}}, bus.mem_offset};
        if (pre_we) begin
            for (int i = 0; i < 4; i++) mem[pre_addr + 10'(i)] <= pre_data[8*i +: 8];
        end else if (bus.mem_write) begin
            for (int i = 0; i < nbytes(bus.mem_funct3); i++)
                mem[m_a[9:0] + 10'(i)] <= bus.mem_value[8*i +: 8];
        end
        if (bus.mem_read)
            bus.mem_data <= extend({mem[m_a[9:0] + 10'd3], mem[m_a[9:0] + 10'd2],
                                    mem[m_a[9:0] + 10'd1], mem[m_a[9:0]]}, bus.mem_funct3);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: kind 0 = exception, 1 = load, 2 = store.
    task automatic ref_classify(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] ea, output int kind, output logic [3:0] cause);
        cause = 4'd0;
        if (ld == st)                                           begin kind = 0; cause = 4'd2; end
        else if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) begin kind = 0; cause = 4'd2; end
        else if (st && f3 > 3'd2)                               begin kind = 0; cause = 4'd2; end
        else if ((f3[1:0] == 2'b01 && ea[0]) || (f3[1:0] == 2'b10 && ea[1:0] != 2'b00))
                                                                begin kind = 0; cause = ld ? 4'd4 : 4'd6; end
        else kind = ld ? 1 : 2;
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[a + 10'(i)] = d[8*i +: 8];
    endtask

    task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] base,
                             input logic [11:0] off, input logic [31:0] wd, input logic [4:0] rd);
        bus.req_valid = 1'b1; bus.req_load = ld; bus.req_store = st; bus.req_funct3 = f3;
        bus.req_base = base; bus.req_offset = off; bus.req_wdata = wd; bus.req_rd = rd;
    endtask

    task automatic do_req(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [11:0] off, input logic [31:0] wd, input logic [4:0] rd, input int hold);
        int kind;
        int lat;
        logic [3:0]  cause;
        logic [31:0] ea, data;
        ea = base + {{20{off[11]}}, off};
        ref_classify(ld, st, f3, ea, kind, cause);
        data = extend({ref_mem[ea[9:0] + 10'd3], ref_mem[ea[9:0] + 10'd2],
                       ref_mem[ea[9:0] + 10'd1], ref_mem[ea[9:0]]}, f3);
        @(negedge clk);
        drive_req(ld, st, f3, base, off, wd, rd);
        bus.wb_ready = (hold == 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_eq("mem_read", 32'(bus.mem_read), 32'(kind == 1));
        check_eq("mem_write", 32'(bus.mem_write), 32'(kind == 2));
        check_eq("exc_valid", 32'(bus.exc_valid), 32'(kind == 0));
        if (kind == 0) begin
            check_eq("exc_cause", 32'(bus.exc_cause), 32'(cause));
            check_eq("exc_addr", bus.exc_addr, ea);
            bus.wb_ready = 1'b1;
            @(negedge clk);
            check_eq("exc_pulse_end", 32'(bus.exc_valid), 32'd0);
            check_eq("fault_idle", 32'({bus.req_ready, busy, bus.wb_valid}), 32'(3'b100));
        end else begin
            check_eq("mem_addr", bus.mem_addr, base);
            check_eq("mem_offset", 32'(bus.mem_offset), 32'(off));
            check_eq("mem_funct3", 32'(bus.mem_funct3), 32'(f3));
            if (kind == 2) check_eq("mem_value", bus.mem_value, wd);
            // Junk on the request bus while busy must be ignored.
            drive_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      $urandom, 12'($urandom), $urandom, 5'($urandom));
            lat = 0;
            for (int c = 2; c <= 8 && lat == 0; c++) begin
                @(negedge clk);
                if (bus.wb_valid) lat = c;
                check_eq("strobe_once", 32'({bus.mem_read, bus.mem_write, bus.exc_valid}), 32'd0);
            end
            bus.req_valid = 1'b0;
            check_eq("wb_latency", lat, (kind == 1) ? 3 : 2);
            if (lat != 0) begin
                check_eq("wb_we", 32'(bus.wb_we), 32'(kind == 1));
                check_eq("wb_rd", 32'(bus.wb_rd), 32'(rd));
                if (kind == 1) check_eq("wb_data", bus.wb_data, data);
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    check_eq("hold_valid_ready", 32'({bus.wb_valid, bus.req_ready}), 32'(2'b10));
                    if (kind == 1) check_eq("hold_data", bus.wb_data, data);
                end
            end
            bus.wb_ready = 1'b1;
            @(negedge clk);
            check_eq("resp_done", 32'({bus.wb_valid, bus.req_ready, busy}), 32'(3'b010));
            if (kind == 2)
                for (int i = 0; i < nbytes(f3); i++) ref_mem[ea[9:0] + 10'(i)] = wd[8*i +: 8];
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  lf [5];
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [11:0] off;
        int          r, na_r0, na_e0;
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst = 1'b1;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
        bus.req_base = '0; bus.req_offset = '0; bus.req_wdata = '0; bus.req_rd = '0;
        bus.wb_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        check_eq("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check_eq("rst_exc_valid", 32'(bus.exc_valid), 32'd0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
        check_eq("rst_wb_data", bus.wb_data, 32'd0);
        check_eq("rst_exc_cause", 32'(bus.exc_cause), 32'd0);
        check_eq("rst_wb_we", 32'(bus.wb_we), 32'd0);

        // Directed cases
        preload(10'h14, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, LW, 32'h10, 12'd4, 32'd0, 5'd5, 0);
        do_req(1'b0, 1'b1, SW, 32'h20, 12'hFFC, 32'h12345678, 5'd0, 0);
        do_req(1'b1, 1'b0, LW, 32'h1C, 12'd0, 32'd0, 5'd9, 0);

        repeat (6) @(negedge clk);
        na_r0 = na_reads; na_e0 = na_exc;
        do_req(1'b1, 1'b0, LH, 32'h20, 12'd1, 32'd0, 5'd3, 0);
        repeat (6) @(negedge clk);
        check_eq("noalign_reads", na_reads - na_r0, 32'd1);
        check_eq("noalign_exc", na_exc - na_e0, 32'd0);

        do_req(1'b0, 1'b1, SW, 32'h20, 12'd2, 32'h55AA55AA, 5'd0, 0);
        do_req(1'b1, 1'b0, 3'd3, 32'h40, 12'd0, 32'd0, 5'd1, 0);
        do_req(1'b1, 1'b1, LW, 32'h40, 12'd0, 32'd0, 5'd1, 0);
        do_req(1'b0, 1'b0, LW, 32'h40, 12'd0, 32'd0, 5'd1, 0);
        do_req(1'b1, 1'b0, 3'd6, 32'h22, 12'd0, 32'd0, 5'd1, 0);
        do_req(1'b0, 1'b1, 3'd5, 32'h21, 12'd0, 32'd7, 5'd1, 0);
        preload(10'h30, 32'h000000F0);
        do_req(1'b1, 1'b0, LB, 32'h30, 12'd0, 32'd0, 5'd17, 5);

        // Reset while a store sits in ISSUE
        preload(10'h08, 32'h11223344);
        @(negedge clk);
        drive_req(1'b0, 1'b1, SB, 32'h08, 12'd0, 32'h000000A5, 5'd0);
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        check_eq("rst_pre_write", 32'(bus.mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_write_drop", 32'({bus.mem_write, bus.mem_read, bus.wb_valid, bus.exc_valid}), 32'd0);
        check_eq("rst_async_idle", 32'({bus.req_ready, busy}), 32'(2'b10));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mem_kept", 32'(mem[8]), 32'(ref_mem[8]));
        check_eq("rst_after_idle", 32'({bus.req_ready, busy}), 32'(2'b10));
        do_req(1'b1, 1'b0, LB, 32'h08, 12'd0, 32'd0, 5'd2, 0);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            ld = (r == 0) || (r >= 2 && r <= 5);
            st = (r == 0) || (r >= 6);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (ld && !st)            f3 = lf[$urandom_range(0, 4)];
            else                           f3 = 3'($urandom_range(0, 2));
            base = 32'($urandom_range(64, 768));
            off  = 12'($urandom_range(0, 63) - 32);
            if ($urandom_range(0, 1) == 1) begin
                base[1:0] = 2'b00;
                off[1:0]  = 2'b00;
            end
            do_req(ld, st, f3, base, off, $urandom, 5'($urandom), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
